// File: rtl/rgb565_frame_sequencer.sv
// Run controller for the RGB565 pattern generator: arms, enables and sequences frames,
// with optional pattern auto-cycling, an inter-frame gap and a frame watchdog.
module rgb565_frame_sequencer #(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned FRAME_CNT_W    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2**22
) (
    input  logic                   pattern_generetor_clk,
    input  logic                   pattern_reset,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [FRAME_CNT_W-1:0] num_frames_i,
    input  logic [1:0]             pattern_mode_i,
    input  logic                   auto_cycle_i,
    input  logic [12:0]            h_res_i,
    input  logic [11:0]            v_res_i,
    input  logic                   sink_ready_i,
    input  logic                   gen_frame_rdy_i,
    output logic                   gen_reset_o,
    output logic                   gen_enable_o,
    output logic [1:0]             gen_selector_o,
    output logic [12:0]            gen_h_res_o,
    output logic [11:0]            gen_v_res_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [FRAME_CNT_W-1:0] frames_done_o,
    output logic                   timeout_o
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, ARM, RUN, GAP, DONE} state_t;

    state_t                 state;
    logic [FRAME_CNT_W-1:0] num_frames;
    logic [FRAME_CNT_W-1:0] frames_inc;
    logic                   auto_cycle;
    logic [WD_W-1:0]        wdog;
    logic [WD_W-1:0]        wdog_inc;
    logic [GAP_W-1:0]       gap_cnt;

    assign frames_inc = (&frames_done_o) ? frames_done_o : frames_done_o + 1'b1;
    assign wdog_inc   = wdog + 1'b1;

    always_ff @(posedge pattern_generetor_clk or posedge pattern_reset) begin
        if (pattern_reset) begin
            state          <= IDLE;
            num_frames     <= '0;
            auto_cycle     <= 1'b0;
            wdog           <= '0;
            gap_cnt        <= '0;
            gen_reset_o    <= 1'b0;
            gen_enable_o   <= 1'b0;
            gen_selector_o <= '0;
            gen_h_res_o    <= '0;
            gen_v_res_o    <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            frames_done_o  <= '0;
            timeout_o      <= 1'b0;
        end else begin
            gen_reset_o <= 1'b0;
            done_o      <= 1'b0;
            case (state)
                IDLE: begin
                    gen_enable_o <= 1'b0;
                    if (start_i && (h_res_i != '0) && (v_res_i != '0)) begin
                        num_frames     <= num_frames_i;
                        auto_cycle     <= auto_cycle_i;
                        gen_selector_o <= pattern_mode_i;
                        gen_h_res_o    <= h_res_i;
                        gen_v_res_o    <= v_res_i;
                        frames_done_o  <= '0;
                        timeout_o      <= 1'b0;
                        gen_reset_o    <= 1'b1;
                        busy_o         <= 1'b1;
                        state          <= ARM;
                    end
                end
                ARM: begin
                    gen_enable_o <= 1'b0;
                    wdog         <= '0;
                    if (stop_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        gen_enable_o <= 1'b0;
                        busy_o       <= 1'b0;
                        state        <= IDLE;
                    end else if (gen_frame_rdy_i) begin
                        gen_enable_o  <= 1'b0;
                        frames_done_o <= frames_inc;
                        if (auto_cycle)
                            gen_selector_o <= gen_selector_o + 2'd1;
                        if ((num_frames != '0) && (frames_inc == num_frames)) begin
                            state <= DONE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end else if (gen_enable_o && (wdog_inc == WD_W'(TIMEOUT_CYCLES))) begin
                        timeout_o    <= 1'b1;
                        gen_enable_o <= 1'b0;
                        busy_o       <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        gen_enable_o <= sink_ready_i;
                        if (gen_enable_o)
                            wdog <= wdog_inc;
                    end
                end
                GAP: begin
                    gen_enable_o <= 1'b0;
                    if (stop_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        gen_reset_o <= 1'b1;
                        state       <= ARM;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // done_o is raised on leaving DONE so a stop in this cycle can still suppress it
                    gen_enable_o <= 1'b0;
                    done_o       <= ~stop_i;
                    busy_o       <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    gen_enable_o <= 1'b0;
                    busy_o       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb565_frame_sequencer.sv
// Self-checking bench for rgb565_frame_sequencer with a simple pixel-counting generator model.
module tb_rgb565_frame_sequencer;

    localparam int unsigned GAP = 5;
    localparam int unsigned FW  = 8;
    localparam int unsigned TO  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, auto_cyc, sink, frame_rdy;
    logic [FW-1:0] num_frames;
    logic [1:0]    mode;
    logic [12:0]   h_res;
    logic [11:0]   v_res;
    logic          gen_reset, gen_enable, busy, done, timeout;
    logic [1:0]    selector;
    logic [12:0]   gen_h;
    logic [11:0]   gen_v;
    logic [FW-1:0] frames_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rgb565_frame_sequencer #(
        .GAP_CYCLES    (GAP),
        .FRAME_CNT_W   (FW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pattern_generetor_clk(clk),
        .pattern_reset        (rst),
        .start_i              (start),
        .stop_i               (stop),
        .num_frames_i         (num_frames),
        .pattern_mode_i       (mode),
        .auto_cycle_i         (auto_cyc),
        .h_res_i              (h_res),
        .v_res_i              (v_res),
        .sink_ready_i         (sink),
        .gen_frame_rdy_i      (frame_rdy),
        .gen_reset_o          (gen_reset),
        .gen_enable_o         (gen_enable),
        .gen_selector_o       (selector),
        .gen_h_res_o          (gen_h),
        .gen_v_res_o          (gen_v),
        .busy_o               (busy),
        .done_o               (done),
        .frames_done_o        (frames_done),
        .timeout_o            (timeout)
    );

    // Generator model: counts enabled pixels, flags completion at h*v
    logic [24:0] pix = '0;
    logic [24:0] target;
    logic        rdy_sel = 1'b0;
    logic        rdy_man = 1'b0;
    assign target    = 25'(gen_h) * 25'(gen_v);
    assign frame_rdy = rdy_sel ? rdy_man : ((target != '0) && (pix == target));

    always @(posedge clk) begin
        if (gen_reset) pix <= '0;
        else if (gen_enable && (pix != target)) pix <= pix + 1'b1;
    end

    // Event monitor
    int   cyc = 0, rst_cnt = 0, done_cnt = 0, en_cnt = 0, en_nordy_cnt = 0, last_rdy = 0;
    logic rdy_prev = 1'b0;
    int   rst_sel[64];
    int   rst_gap[64];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (gen_reset) begin
            rst_sel[rst_cnt & 63] <= int'(selector);
            rst_gap[rst_cnt & 63] <= cyc - last_rdy;
            rst_cnt <= rst_cnt + 1;
        end
        if (frame_rdy && !rdy_prev) last_rdy <= cyc;
        rdy_prev <= frame_rdy;
        if (done) done_cnt <= done_cnt + 1;
        if (gen_enable) en_cnt <= en_cnt + 1;
        if (gen_enable && !frame_rdy) en_nordy_cnt <= en_nordy_cnt + 1;
    end

    typedef struct {
        logic        start;
        logic [12:0] h;
        logic [11:0] v;
        logic [1:0]  mode;
        logic        exp_busy;
        logic [12:0] exp_h;
        logic [11:0] exp_v;
        logic [1:0]  exp_sel;
    } vec_t;
    vec_t vt[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {gen_reset, gen_enable, selector, gen_h, gen_v, busy, done, frames_done, timeout}, 64'd0);
    endtask

    task automatic start_cfg(input logic [FW-1:0] n, input logic [1:0] m, input logic a,
                             input logic [12:0] h, input logic [11:0] v);
        num_frames = n; mode = m; auto_cyc = a; h_res = h; v_res = v;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check(name, found, 1'b1);
    endtask

    task automatic run_single(input string tag);
        int d0, r0, e0;
        d0 = done_cnt; r0 = rst_cnt; e0 = en_nordy_cnt;
        sink = 1'b1;
        start_cfg(8'd1, 2'd2, 1'b0, 13'd8, 12'd4);
        check({tag, "_arm_reset"}, gen_reset, 1'b1);
        check({tag, "_arm_enable"}, gen_enable, 1'b0);
        check({tag, "_arm_busy"}, busy, 1'b1);
        step();
        check({tag, "_reset_one_cycle"}, gen_reset, 1'b0);
        wait_done({tag, "_done_seen"});
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_frames_done"}, frames_done, 8'd1);
        check({tag, "_selector"}, selector, 2'd2);
        check({tag, "_res"}, {gen_h, gen_v}, {13'd8, 12'd4});
        check({tag, "_timeout"}, timeout, 1'b0);
        check({tag, "_reset_pulses"}, rst_cnt - r0, 1);
        check({tag, "_enabled_cycles"}, en_nordy_cnt - e0, 32);
        step();
        check({tag, "_done_one_cycle"}, done, 1'b0);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got expired, expected finish");
        $fatal(1);
    end

    initial begin
        int d0, r0, e0, k;
        logic found;
        rst = 1'b1; start = 1'b0; stop = 1'b0; auto_cyc = 1'b0; sink = 1'b0;
        num_frames = '0; mode = '0; h_res = '0; v_res = '0;
        step(); step();
        check_all_zero("reset_state");
        @(negedge clk) rst = 1'b0;
        step();
        check_all_zero("after_reset_release");

        // Start acceptance and configuration latching
        vt[0] = '{1'b1, 13'd8,    12'd4,    2'd2, 1'b1, 13'd8,    12'd4,    2'd2};
        vt[1] = '{1'b1, 13'd0,    12'd4,    2'd1, 1'b0, 13'd8,    12'd4,    2'd2};
        vt[2] = '{1'b1, 13'd8,    12'd0,    2'd3, 1'b0, 13'd8,    12'd4,    2'd2};
        vt[3] = '{1'b0, 13'd5,    12'd5,    2'd1, 1'b0, 13'd8,    12'd4,    2'd2};
        vt[4] = '{1'b1, 13'd1,    12'd1,    2'd1, 1'b1, 13'd1,    12'd1,    2'd1};
        vt[5] = '{1'b1, 13'd8191, 12'd4095, 2'd0, 1'b1, 13'd8191, 12'd4095, 2'd0};
        for (int i = 0; i < 6; i++) begin
            num_frames = 8'd1; auto_cyc = 1'b0;
            h_res = vt[i].h; v_res = vt[i].v; mode = vt[i].mode;
            start = vt[i].start;
            step();
            start = 1'b0;
            check($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
            check($sformatf("vec%0d_gen_reset", i), gen_reset, vt[i].exp_busy);
            check($sformatf("vec%0d_res", i), {gen_h, gen_v}, {vt[i].exp_h, vt[i].exp_v});
            check($sformatf("vec%0d_selector", i), selector, vt[i].exp_sel);
            stop = 1'b1;
            step();
            stop = 1'b0;
            check($sformatf("vec%0d_stopped", i), {busy, gen_reset, gen_enable}, 3'b000);
        end

        // Test 1: single frame
        run_single("t1");

        // Test 2: three frames with auto-cycling
        r0 = rst_cnt; sink = 1'b1;
        start_cfg(8'd3, 2'd3, 1'b1, 13'd4, 12'd2);
        wait_done("t2_done_seen");
        check("t2_frames_done", frames_done, 8'd3);
        check("t2_busy", busy, 1'b0);
        check("t2_reset_pulses", rst_cnt - r0, 3);
        check("t2_sel_frame0", rst_sel[r0 & 63], 3);
        check("t2_sel_frame1", rst_sel[(r0 + 1) & 63], 0);
        check("t2_sel_frame2", rst_sel[(r0 + 2) & 63], 1);
        check("t2_gap1", rst_gap[(r0 + 1) & 63], GAP + 1);
        check("t2_gap2", rst_gap[(r0 + 2) & 63], GAP + 1);
        check("t2_final_selector", selector, 2'd2);
        step();

        // Test 3: back-pressure toggling every 5 cycles
        e0 = en_nordy_cnt;
        num_frames = 8'd1; mode = 2'd1; auto_cyc = 1'b0; h_res = 13'd8; v_res = 12'd4;
        start = 1'b1; sink = 1'b0;
        found = 1'b0;
        for (k = 1; k < 600; k++) begin
            step();
            start = 1'b0;
            if (done) begin
                found = 1'b1;
                break;
            end
            if (k >= 3 && k <= 40) check($sformatf("t3_enable_lag_k%0d", k), gen_enable, sink);
            sink = ((k / 5) % 2) == 1;
        end
        check("t3_done_seen", found, 1'b1);
        check("t3_frames_done", frames_done, 8'd1);
        check("t3_no_timeout", timeout, 1'b0);
        check("t3_enabled_cycles", en_nordy_cnt - e0, 32);
        sink = 1'b1;
        step();

        // Test 4: watchdog
        rdy_sel = 1'b1; rdy_man = 1'b0;
        d0 = done_cnt; e0 = en_cnt;
        start_cfg(8'd1, 2'd0, 1'b0, 13'd8, 12'd4);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (!busy) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_returned_idle", found, 1'b1);
        check("t4_timeout", timeout, 1'b1);
        check("t4_enabled_cycles", en_cnt - e0, int'(TO));
        check("t4_enable_off", gen_enable, 1'b0);
        check("t4_frames_done", frames_done, 8'd0);
        step();
        check("t4_no_done", done_cnt - d0, 0);
        rdy_sel = 1'b0;
        start_cfg(8'd1, 2'd0, 1'b0, 13'd8, 12'd4);
        check("t4_timeout_cleared", timeout, 1'b0);
        wait_done("t4_restart_done");
        step();

        // Test 5: continuous mode, stop coinciding with frame_rdy
        rdy_sel = 1'b1; rdy_man = 1'b0;
        d0 = done_cnt;
        start_cfg(8'd0, 2'd1, 1'b0, 13'd8, 12'd4);
        for (int i = 0; i < 10; i++) step();
        rdy_man = 1'b1;
        step();
        rdy_man = 1'b0;
        check("t5_frame1_count", frames_done, 8'd1);
        check("t5_still_busy", busy, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (gen_reset) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_rearmed", found, 1'b1);
        for (int i = 0; i < 5; i++) step();
        rdy_man = 1'b1; stop = 1'b1;
        step();
        rdy_man = 1'b0; stop = 1'b0;
        check("t5_stop_idle", {busy, gen_enable, gen_reset}, 3'b000);
        check("t5_count_unchanged", frames_done, 8'd1);
        step(); step();
        check("t5_no_done", done_cnt - d0, 0);
        start_cfg(8'd1, 2'd1, 1'b0, 13'd0, 12'd4);
        check("t5_zero_res_ignored", {busy, gen_reset}, 2'b00);
        rdy_sel = 1'b0;

        // Test 6: asynchronous reset in RUN and in GAP
        start_cfg(8'd1, 2'd2, 1'b0, 13'd8, 12'd4);
        for (int i = 0; i < 8; i++) step();
        #2 rst = 1'b1;
        #1 check_all_zero("t6_reset_in_run");
        @(negedge clk) rst = 1'b0;
        step();
        start_cfg(8'd2, 2'd2, 1'b0, 13'd4, 12'd2);
        step(); step();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (frame_rdy) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("t6_frame_rdy_seen", found, 1'b1);
        step();
        check("t6_in_gap", {busy, gen_enable, gen_reset}, 3'b100);
        #2 rst = 1'b1;
        #1 check_all_zero("t6_reset_in_gap");
        @(negedge clk) rst = 1'b0;
        step();
        run_single("t6_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
